mux_bit_deser: RTL
==================

// Module: mux_bit_deser
// PURPOSE
//  Downstream consumer of the registered 2:1 bit mux output (y).
//  - Collects the serial bit stream into WIDTH-bit words and buffers them in a small FIFO.
//  - Presents buffered words to the next stage over a valid/ready handshake.
//  - Counts words lost to backpressure.
// PARAMETERS
//  WIDTH      8   bits per word (>=2)
//  MSB_FIRST  1   1: first bit received lands in word_data[WIDTH-1]; 0: lands in word_data[0]
//  DEPTH      2   output FIFO depth in words (power of 2, >=2)
//  OVF_W      8   width of the overflow counter
// PORTS
//  clk          in   1       rising-edge clock
//  rst_n        in   1       asynchronous, active-low reset
//  bit_in       in   1       serial bit, driven by the mux output y
//  bit_en       in   1       bit_in is valid this cycle
//  frame_start  in   1       realign: the current/next accepted bit is bit 0 of a new word
//  word_data    out  WIDTH   head-of-FIFO word
//  word_valid   out  1       FIFO not empty
//  word_ready   in   1       consumer accepts word_data when word_valid && word_ready
//  partial_drop out  1       one-cycle pulse: a partial word was discarded by frame_start
//  ovf_cnt      out  OVF_W   completed words dropped because the FIFO was full; saturating
//  busy         out  1       shifter holds >=1 bit of an incomplete word
// BEHAVIOUR
//  Reset (rst_n=0, async): all outputs, FIFO pointers, bit count, shifter and FSM cleared
//   immediately; word_valid=0, partial_drop=0, ovf_cnt=0, busy=0, word_data=0.
//   A word in flight at reset is lost and is not counted as overflow.
//  FSM states
//   IDLE  -> SHIFT on bit_en; bit count becomes 1.
//   SHIFT -> stays while cnt < WIDTH-1 on bit_en.
//   SHIFT -> IDLE on bit_en with cnt == WIDTH-1; word complete, cnt resets to 0.
//   busy = (state == SHIFT).
//  Word assembly
//   - Shifter is WIDTH bits wide; bit count is $clog2(WIDTH) bits.
//   - bit_en=0 holds the shifter and the count.
//  Latency
//   - A completed word is written into the FIFO on the same edge that accepts its last bit.
//   - word_valid rises one cycle after that last bit is presented, if the FIFO was empty.
//  Handshake
//   - word_data is stable while word_valid=1 and word_ready=0.
//   - A pop occurs on each edge where word_valid && word_ready.
//   - FIFO order is strict FIFO; pointers wrap modulo DEPTH, with an extra bit to tell full from empty.
//  Full FIFO
//   - Push is allowed if the FIFO is not full, or if a pop occurs on the same edge (push and pop both happen).
//   - Otherwise the completed word is discarded and ovf_cnt increments, holding at 2^OVF_W-1.
//   - The shifter never stalls; bits are not backpressured.
//  frame_start
//   - Asserted with cnt != 0: the partial word is discarded, partial_drop pulses on the next cycle, and cnt resets.
//   - Asserted with bit_en=1: that bit is taken as bit 0 of the new word (state SHIFT, cnt=1).
//   - Asserted with bit_en=0: state becomes IDLE, cnt=0.
//   - frame_start with cnt == 0 produces no pulse.
//   - When frame_start coincides with the bit that would complete a word, frame_start wins: the partial word is
//     dropped, partial_drop pulses, and the bit starts the new word.
//  Empty FIFO: word_ready is ignored; there is no pop and no pointer movement.
// STRUCTURE
//  - Package mux_bit_deser_pkg: state enum type (IDLE, SHIFT) and a clog2-based width helper for the counter and
//    the pointers.
//  - Sub-module mux_bit_deser_fifo:
//    - Parameters WIDTH and DEPTH.
//    - Ports push, push_data, pop, full, empty, head_data.
//    - Register-based storage; async reset on the pointers only.
//  - Top level holds the FSM, the shifter, the overflow counter and the partial_drop register.
// TESTING
//  1. WIDTH=8, MSB_FIRST=1, word_ready=1; 8 consecutive bit_en bits 1,0,1,0,0,1,1,0
//     -> word_data=8'hA6 with word_valid=1 for exactly one cycle, one cycle after the 8th bit.
//  2. MSB_FIRST=0, same bit sequence -> word_data=8'h65.
//  3. word_ready=0; stream 5 full words with DEPTH=2
//     -> word_valid held high, first 2 words retained in order, ovf_cnt=3.
//     Then raise word_ready -> 2 pops in order, then word_valid=0.
//  4. 3 bits, then frame_start with bit_en=1 and 7 further bits
//     -> partial_drop pulses once.
//     Resulting word = frame_start bit followed by the 7 bits; ovf_cnt unchanged.
//  5. FIFO full, word_ready=1 on the same edge as the final bit of a new word
//     -> one pop and one push; no overflow; order preserved.
//  6. Deassert rst_n for 1 cycle mid-word with 1 word buffered
//     -> word_valid=0, busy=0 immediately.
//     Next 8 bits form a clean word; ovf_cnt=0.

Source files
------------

// File: rtl/mux_bit_deser_pkg.sv
// Shared types and helpers for the serial-to-word deserializer.
//   state_e : word-assembly FSM states (IDLE, SHIFT)
//   cnt_w() : width of a counter/pointer indexing n items (never below 1 bit)
package mux_bit_deser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // $clog2 returns 0 for n<=1, which would give a zero-width vector.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_bit_deser_fifo.sv
// Small register-based word FIFO.
//   clk, rst_n : clock, asynchronous active-low reset (pointers only)
//   push       : write push_data (taken if not full, or if popping on the same edge)
//   push_data  : word to write
//   pop        : remove head word (ignored while empty)
//   full       : DEPTH words stored
//   empty      : no words stored
//   head_data  : oldest word, forced to zero while empty
module mux_bit_deser_fifo
  import mux_bit_deser_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_data
);

  localparam int unsigned AW = cnt_w(DEPTH);
  localparam int unsigned PW = AW + 1;

  // Extra MSB on each pointer distinguishes full from empty when the
  // index bits coincide.
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  assign do_pop  = pop && !empty;
  // A simultaneous pop frees the slot the push needs.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + PW'(1);
    if (do_pop)  rptr_d = rptr_q + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= push_data;
  end

  // Storage is not reset, so mask the stale head while empty.
  assign head_data = empty ? '0 : mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/mux_bit_deser.sv
// Deserializer for the registered 2:1 bit-mux output stream.
// Collects bits into WIDTH-bit words, buffers them in a DEPTH-word FIFO and
// offers them over a valid/ready handshake. Bits are never backpressured:
// a word completing against a full FIFO is dropped and counted.
//   clk, rst_n   : clock, asynchronous active-low reset
//   bit_in       : serial bit
//   bit_en       : bit_in valid this cycle
//   frame_start  : accepted bit (if any) begins a new word; partial word dropped
//   word_data    : head-of-FIFO word (0 when empty)
//   word_valid   : FIFO not empty
//   word_ready   : consumer accepts word_data when word_valid && word_ready
//   partial_drop : one-cycle pulse after a partial word is discarded
//   ovf_cnt      : saturating count of completed words lost to a full FIFO
//   busy         : an incomplete word is being assembled
module mux_bit_deser
  import mux_bit_deser_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned OVF_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_en,
  input  logic             frame_start,
  output logic [WIDTH-1:0] word_data,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             partial_drop,
  output logic [OVF_W-1:0] ovf_cnt,
  output logic             busy
);

  localparam int unsigned    CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             pd_q, pd_d;
  logic [OVF_W-1:0] ovf_q, ovf_d;

  logic             word_done;
  logic [WIDTH-1:0] sh_next;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;

  // MSB-first shifts left so the first bit ends in [WIDTH-1];
  // LSB-first shifts right so the first bit ends in [0].
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] sh,
                                                input logic              b);
    if (MSB_FIRST) return {sh[WIDTH-2:0], b};
    else           return {b, sh[WIDTH-1:1]};
  endfunction

  assign sh_next = shift_in(sh_q, bit_in);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    pd_d      = 1'b0;
    word_done = 1'b0;
    if (frame_start) begin
      // Realign takes priority, even over the bit that would finish a word.
      pd_d = (cnt_q != '0);
      if (bit_en) begin
        state_d = SHIFT;
        cnt_d   = CW'(1);
        sh_d    = sh_next;
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end else if (bit_en) begin
      // Stale shifter bits need no clearing: a full word shifts them out.
      sh_d = sh_next;
      unique case (state_q)
        IDLE: begin
          state_d = SHIFT;
          cnt_d   = CW'(1);
        end
        SHIFT: begin
          if (cnt_q == LAST) begin
            word_done = 1'b1;
            state_d   = IDLE;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign pop = word_valid && word_ready;

  always_comb begin
    ovf_d = ovf_q;
    if (word_done && fifo_full && !pop && (ovf_q != '1)) begin
      ovf_d = ovf_q + OVF_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      pd_q    <= 1'b0;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      pd_q    <= pd_d;
      ovf_q   <= ovf_d;
    end
  end

  // The completed word is the shifter plus the bit accepted on this edge.
  mux_bit_deser_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (word_done),
    .push_data (sh_next),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head_data (word_data)
  );

  assign word_valid   = !fifo_empty;
  assign partial_drop = pd_q;
  assign ovf_cnt      = ovf_q;
  assign busy         = (state_q == SHIFT);

endmodule
